// File: rtl/sim_err_watchdog_pkg.sv
// Shared definitions for the run watchdog: FSM state encoding and fault codes.
package sim_err_watchdog_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDone  = 2'd2,
    StFault = 2'd3
  } wd_state_e;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrExt   = 2'd1;
  localparam logic [1:0] ErrCycle = 2'd2;
  localparam logic [1:0] ErrStall = 2'd3;

endpackage

// File: rtl/sim_err_watchdog_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sim_err_watchdog_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sim_err_watchdog.sv
// Run monitor: watches commit heartbeat, halt and external faults, and raises a sticky
// err with a reason code, or a sticky done on normal completion.
module sim_err_watchdog
  import sim_err_watchdog_pkg::*;
#(
  parameter int unsigned CYCLE_LIMIT = 1000,
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             commit,
  input  logic             halt,
  input  logic [3:0]       err_src,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       err_srcq,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Limits compared one bit wider than the counters so cnt+1 never wraps.
  localparam logic [CNT_W:0] CycleLim = (CNT_W+1)'(CYCLE_LIMIT);
  localparam logic [CNT_W:0] StallLim = (CNT_W+1)'(STALL_LIMIT);
  localparam logic [CNT_W:0] OneW     = {{CNT_W{1'b0}}, 1'b1};

  wd_state_e        state_q, state_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       srcq_q, srcq_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W:0]   cyc_next, stall_next;
  logic             cyc_clr, cyc_inc, stall_clr, stall_inc;

  assign cyc_next   = {1'b0, cycle_cnt} + OneW;
  assign stall_next = {1'b0, stall_cnt} + OneW;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    code_d    = code_q;
    srcq_d    = srcq_q;
    done_d    = done_q;
    cyc_clr   = 1'b0;
    cyc_inc   = 1'b0;
    stall_clr = 1'b0;
    stall_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          cyc_clr   = 1'b1;
          stall_clr = 1'b1;
        end
      end
      StRun: begin
        if (err_src != 4'd0) begin
          state_d = StFault;
          err_d   = 1'b1;
          code_d  = ErrExt;
          srcq_d  = err_src;
        end else if (cyc_next == CycleLim) begin
          state_d = StFault;
          err_d   = 1'b1;
          code_d  = ErrCycle;
        end else if (!commit && (stall_next == StallLim)) begin
          state_d = StFault;
          err_d   = 1'b1;
          code_d  = ErrStall;
        end else if (halt) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cyc_inc   = 1'b1;
          stall_clr = commit;
          stall_inc = !commit;
        end
      end
      StDone, StFault: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      srcq_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      code_q  <= code_d;
      srcq_q  <= srcq_d;
      done_q  <= done_d;
    end
  end

  sim_err_watchdog_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cyc_clr),
    .inc(cyc_inc),
    .cnt(cycle_cnt)
  );

  sim_err_watchdog_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .clr(stall_clr),
    .inc(stall_inc),
    .cnt(stall_cnt)
  );

  assign err      = err_q;
  assign err_code = code_q;
  assign err_srcq = srcq_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sim_err_watchdog.sv
// Bench for sim_err_watchdog: directed and random runs scored against a per-run outcome model.
module tb_sim_err_watchdog;

  localparam int CL = 50;
  localparam int SL = 8;
  localparam int CW = 16;
  localparam int MaxLen = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          commit = 1'b0;
  logic          halt = 1'b0;
  logic [3:0]    err_src = 4'd0;
  logic          err;
  logic [1:0]    err_code;
  logic [3:0]    err_srcq;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Per-RUN-cycle stimulus for one run.
  logic       cm[MaxLen];
  logic       hl[MaxLen];
  logic [3:0] es[MaxLen];

  always #5 clk = ~clk;

  sim_err_watchdog #(
    .CYCLE_LIMIT(CL),
    .STALL_LIMIT(SL),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .commit(commit),
    .halt(halt),
    .err_src(err_src),
    .err(err),
    .err_code(err_code),
    .err_srcq(err_srcq),
    .done(done),
    .cycle_cnt(cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_err, input logic [1:0] e_code,
                           input logic [3:0] e_srcq, input logic e_done, input int e_cnt);
    check_eq({tag, ".err"}, 32'(err), 32'(e_err));
    check_eq({tag, ".err_code"}, 32'(err_code), 32'(e_code));
    check_eq({tag, ".err_srcq"}, 32'(err_srcq), 32'(e_srcq));
    check_eq({tag, ".done"}, 32'(done), 32'(e_done));
    check_eq({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e_cnt));
  endtask

  task automatic clear_stim();
    for (int j = 0; j < MaxLen; j++) begin
      cm[j] = 1'b0;
      hl[j] = 1'b0;
      es[j] = 4'd0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    start = 1'b0;
    commit = 1'b0;
    halt = 1'b0;
    err_src = 4'd0;
    tick();
    tick();
    check_all("reset", 1'b0, 2'd0, 4'd0, 1'b0, 0);
    rst = 1'b1;
    // IDLE ignores everything but start.
    commit = 1'($urandom_range(1));
    halt = 1'($urandom_range(1));
    err_src = 4'($urandom_range(15));
    tick();
    check_all("idle", 1'b0, 2'd0, 4'd0, 1'b0, 0);
  endtask

  // Scan the stimulus by the fault-priority rules; returns the terminating RUN cycle index.
  task automatic predict(output int k, output logic [1:0] code, output logic [3:0] srcq,
                         output logic dn);
    int stall = 0;
    code = 2'd0;
    srcq = 4'd0;
    dn = 1'b0;
    k = 0;
    for (int j = 0; j < MaxLen; j++) begin
      k = j;
      if (es[j] != 4'd0) begin
        code = 2'd1;
        srcq = es[j];
        break;
      end
      if (j + 1 == CL) begin
        code = 2'd2;
        break;
      end
      if (!cm[j] && stall + 1 == SL) begin
        code = 2'd3;
        break;
      end
      if (hl[j]) begin
        dn = 1'b1;
        break;
      end
      stall = cm[j] ? 0 : stall + 1;
    end
  endtask

  task automatic do_run(input string tag, input int abort_at);
    int         k;
    logic [1:0] code;
    logic [3:0] srcq;
    logic       dn;
    predict(k, code, srcq, dn);
    reset_dut();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= k; j++) begin
      commit = cm[j];
      halt = hl[j];
      err_src = es[j];
      check_all({tag, ".run"}, 1'b0, 2'd0, 4'd0, 1'b0, j);
      if (j == abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        check_all({tag, ".abort"}, 1'b0, 2'd0, 4'd0, 1'b0, 0);
        return;
      end
      tick();
    end
    check_all({tag, ".end"}, !dn, code, srcq, dn, k);
    // Terminal states ignore start and everything else.
    for (int j = 0; j < 3; j++) begin
      start = 1'b1;
      commit = 1'($urandom_range(1));
      halt = 1'($urandom_range(1));
      err_src = 4'($urandom_range(15));
      tick();
      check_all({tag, ".hold"}, !dn, code, srcq, dn, k);
    end
    start = 1'b0;
  endtask

  initial begin
    int p;
    // Commit every cycle, halt at RUN cycle 20.
    clear_stim();
    for (int j = 0; j < MaxLen; j++) cm[j] = 1'b1;
    hl[20] = 1'b1;
    do_run("halt20", -1);
    check_eq("halt20.cnt", 32'(cycle_cnt), 32'd20);

    // No halt: cycle limit.
    clear_stim();
    for (int j = 0; j < MaxLen; j++) cm[j] = 1'b1;
    do_run("cyclim", -1);
    check_eq("cyclim.code", 32'(err_code), 32'd2);

    // Commit through cycle 10 then stop: stall at 18.
    clear_stim();
    for (int j = 0; j <= 10; j++) cm[j] = 1'b1;
    do_run("stall", -1);
    check_eq("stall.cnt", 32'(cycle_cnt), 32'd18);

    // Commit lands on the 8th stall cycle: no fault there, next stall at 26.
    clear_stim();
    for (int j = 0; j <= 10; j++) cm[j] = 1'b1;
    cm[18] = 1'b1;
    do_run("stall_save", -1);
    check_eq("stall_save.cnt", 32'(cycle_cnt), 32'd26);

    // External error and halt together.
    clear_stim();
    for (int j = 0; j < MaxLen; j++) cm[j] = 1'b1;
    es[5] = 4'b0100;
    hl[5] = 1'b1;
    do_run("ext_halt", -1);
    check_eq("ext_halt.srcq", 32'(err_srcq), 32'h4);

    // Asynchronous reset mid-run, then a normal run.
    clear_stim();
    for (int j = 0; j < MaxLen; j++) cm[j] = 1'b1;
    hl[30] = 1'b1;
    do_run("abort", 12);
    do_run("after_abort", -1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(3))
        0: p = 100;
        1: p = 95;
        2: p = 70;
        default: p = 0;
      endcase
      clear_stim();
      for (int j = 0; j < MaxLen; j++) cm[j] = ($urandom_range(99) < p);
      if ($urandom_range(1) == 1) hl[$urandom_range(55)] = 1'b1;
      if ($urandom_range(2) == 0) es[$urandom_range(55)] = 4'($urandom_range(1, 15));
      do_run("rand", ($urandom_range(5) == 0) ? int'($urandom_range(10)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
